// File: rtl/vga_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_ctrl_if
// Description : Pixel-scan bus between the VGA scan controller (master) and
//               the card renderers / pin consumers (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface vga_scan_ctrl_if;
    logic [8:0] rgb_in;
    logic       card_on_in;
    logic [9:0] HCount;
    logic [9:0] VCount;
    logic       pixel_tick;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic [8:0] rgb_out;

    modport master (
        input  rgb_in, card_on_in,
        output HCount, VCount, pixel_tick, frame_start, hsync, vsync, rgb_out
    );

    modport slave (
        output rgb_in, card_on_in,
        input  HCount, VCount, pixel_tick, frame_start, hsync, vsync, rgb_out
    );
endinterface
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_ctrl
// Description : VGA 640x480@60 scan controller. Generates pixel tick, counts
//               and syncs; aligns renderer colour with delayed sync.
//               Optional define BORDER_EN adds a white 1-pixel frame border.
// Revision    : 1.0  initial release
// ============================================================================
module vga_scan_ctrl #(
    parameter int unsigned TICK_DIV   = 2,
    parameter int unsigned RENDER_LAT = 2,
    parameter logic [8:0]  BG_RGB     = 9'h000,
    parameter int unsigned H_VIS      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VIS      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_scan_ctrl_if.master bus
);

    localparam int unsigned    c_TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
    localparam logic [9:0]     c_H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]     c_V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]     c_H_VIS      = 10'(H_VIS);
    localparam logic [9:0]     c_V_VIS      = 10'(V_VIS);
    localparam logic [9:0]     c_HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0]     c_HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]     c_VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0]     c_VS_END     = 10'(V_VIS + V_FP + V_SYNC);

    // Pipeline word: {[vcount, hcount,] hs, vs, vid}; idle = syncs high, blank
`ifdef BORDER_EN
    localparam int unsigned    c_PW         = 23;
    localparam logic [9:0]     c_H_EDGE     = 10'(H_VIS - 1);
    localparam logic [9:0]     c_V_EDGE     = 10'(V_VIS - 1);
`else
    localparam int unsigned    c_PW         = 3;
`endif
    localparam logic [c_PW-1:0] c_PIPE_IDLE = c_PW'(3'b110);

    logic [c_TW-1:0] tick_cnt_q, tick_cnt_d;
    logic            pixel_tick_q;
    logic [9:0]      hcount_q, hcount_d;
    logic [9:0]      vcount_q, vcount_d;
    logic            frame_start_q, frame_start_d;
    logic            hsync_q, vsync_q;
    logic [8:0]      rgb_out_q, rgb_out_d;

    logic            w_hs_raw, w_vs_raw, w_vid_raw;
    logic [c_PW-1:0] w_pipe_in, w_pipe_out;

    // ---------------------------------------------------------------- tick
    always_comb begin
        tick_cnt_d = (tick_cnt_q == c_TICK_LAST) ? '0 : tick_cnt_q + c_TW'(1);
    end

    // Registered strobe is high while the count sits at TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            pixel_tick_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            pixel_tick_q <= (tick_cnt_d == c_TICK_LAST);
        end
    end

    // ------------------------------------------------------------ counters
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (pixel_tick_q) begin
            if (hcount_q == c_H_LAST) begin
                hcount_d = '0;
                if (vcount_q == c_V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 10'd1;
                end
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
        end
    end

    // -------------------------------------------------------------- decode
    assign w_hs_raw  = !((hcount_q >= c_HS_START) && (hcount_q < c_HS_END));
    assign w_vs_raw  = !((vcount_q >= c_VS_START) && (vcount_q < c_VS_END));
    assign w_vid_raw = (hcount_q < c_H_VIS) && (vcount_q < c_V_VIS);

`ifdef BORDER_EN
    assign w_pipe_in = {vcount_q, hcount_q, w_hs_raw, w_vs_raw, w_vid_raw};
`else
    assign w_pipe_in = {w_hs_raw, w_vs_raw, w_vid_raw};
`endif

    // Delay advances every clk so the renderer latency is in clk cycles
    generate
        if (RENDER_LAT == 0) begin : g_no_lat
            assign w_pipe_out = w_pipe_in;
        end else begin : g_lat
            logic [c_PW-1:0] pipe_q [RENDER_LAT];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(RENDER_LAT); i++) begin
                        pipe_q[i] <= c_PIPE_IDLE;
                    end
                end else begin
                    pipe_q[0] <= w_pipe_in;
                    for (int i = 1; i < int'(RENDER_LAT); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end
            assign w_pipe_out = pipe_q[RENDER_LAT-1];
        end
    endgenerate

    // -------------------------------------------------------- output stage
`ifdef BORDER_EN
    logic [9:0] w_h_dly, w_v_dly;
    logic       w_on_border;
    assign w_h_dly     = w_pipe_out[12:3];
    assign w_v_dly     = w_pipe_out[22:13];
    assign w_on_border = (w_h_dly == 10'd0) || (w_h_dly == c_H_EDGE) ||
                         (w_v_dly == 10'd0) || (w_v_dly == c_V_EDGE);
`endif

    always_comb begin
        rgb_out_d = 9'h000;
        if (w_pipe_out[0]) begin
            if (bus.card_on_in) begin
                rgb_out_d = bus.rgb_in;
            end
`ifdef BORDER_EN
            else if (w_on_border) begin
                rgb_out_d = 9'h1FF;
            end
`endif
            else begin
                rgb_out_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_out_q <= 9'h000;
        end else begin
            hsync_q   <= w_pipe_out[2];
            vsync_q   <= w_pipe_out[1];
            rgb_out_q <= rgb_out_d;
        end
    end

    assign bus.HCount      = hcount_q;
    assign bus.VCount      = vcount_q;
    assign bus.pixel_tick  = pixel_tick_q;
    assign bus.frame_start = frame_start_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb_out     = rgb_out_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_ctrl
// Description : Directed bench for vga_scan_ctrl: full-size timing instance
//               plus a shrunken-timing instance for frame-level behaviour.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scan_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_scan_ctrl_if m_if ();
    vga_scan_ctrl_if s_if ();

    vga_scan_ctrl #(
        .TICK_DIV   (2),
        .RENDER_LAT (2),
        .BG_RGB     (9'h049)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    // 16 x 9 frame: H 8/2/3/3, V 4/1/2/2, one clk per pixel
    vga_scan_ctrl #(
        .TICK_DIV   (1),
        .RENDER_LAT (2),
        .BG_RGB     (9'h049),
        .H_VIS (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VIS (4), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

`ifdef BORDER_EN
    localparam int c_BORDER_CLKS = 4;
`else
    localparam int c_BORDER_CLKS = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the first clk of column h on line v of the full-size instance
    task automatic wait_start(input logic [9:0] h, input logic [9:0] v, input int budget);
        int  n     = 0;
        bit  found = 1'b0;
        while (!found && n < budget) begin
            if (m_if.HCount == h && m_if.VCount == v && !m_if.pixel_tick) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        if (!found) check("wait_start_timeout", 32'd0, 32'd1);
    endtask

    // One full line (1600 clks) of pin statistics from the full-size instance
    task automatic meas_line(input logic [8:0] fg, output int n_fg, output int n_zero,
                             output int n_white, output int n_hs_low, output int n_tick);
        n_fg = 0; n_zero = 0; n_white = 0; n_hs_low = 0; n_tick = 0;
        for (int i = 0; i < 1600; i++) begin
            if (m_if.rgb_out == fg)     n_fg++;
            if (m_if.rgb_out == 9'h000) n_zero++;
            if (m_if.rgb_out == 9'h1FF) n_white++;
            if (!m_if.hsync)            n_hs_low++;
            if (m_if.pixel_tick)        n_tick++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n_fg, n_zero, n_white, n_hs_low, n_tick;
        int  n_fs, n_vs_low;
        bit  found;

        m_if.card_on_in = 1'b1;
        m_if.rgb_in     = 9'h1C0;
        s_if.card_on_in = 1'b1;
        s_if.rgb_in     = 9'h1C0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hcount",   32'(m_if.HCount),      32'd0);
        check("rst_vcount",   32'(m_if.VCount),      32'd0);
        check("rst_tick",     32'(m_if.pixel_tick),  32'd0);
        check("rst_fstart",   32'(m_if.frame_start), 32'd0);
        check("rst_hsync",    32'(m_if.hsync),       32'd1);
        check("rst_vsync",    32'(m_if.vsync),       32'd1);
        check("rst_rgb",      32'(m_if.rgb_out),     32'd0);
        check("rst_small_tk", 32'(s_if.pixel_tick),  32'd0);

        // Release: first tick one clk in, HCount steps at TICK_DIV clks,
        // first visible colour RENDER_LAT+1 clks after (0,0)
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tick1",    32'(m_if.pixel_tick),  32'd1);
        check("rel_hcount1",  32'(m_if.HCount),      32'd0);
        check("small_tick1",  32'(s_if.pixel_tick),  32'd1);
        @(negedge clk);
        check("rel_hcount2",  32'(m_if.HCount),      32'd1);
        check("rel_tick2",    32'(m_if.pixel_tick),  32'd0);
        check("rgb_lat_pre",  32'(m_if.rgb_out),     32'd0);
        @(negedge clk);
        check("rgb_lat_first", 32'(m_if.rgb_out),    32'h1C0);

        // Small instance: two full frames of 144 clks each
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (s_if.frame_start) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("small_fs_timeout", 32'd0, 32'd1);
        check("small_fs_h", 32'(s_if.HCount), 32'd0);
        check("small_fs_v", 32'(s_if.VCount), 32'd0);
        n_fs = 0; n_vs_low = 0; n_hs_low = 0; n_tick = 0; n_fg = 0;
        for (int i = 1; i <= 288; i++) begin
            @(negedge clk);
            if (s_if.frame_start)        n_fs++;
            if (!s_if.vsync)             n_vs_low++;
            if (!s_if.hsync)             n_hs_low++;
            if (s_if.pixel_tick)         n_tick++;
            if (s_if.rgb_out == 9'h1C0)  n_fg++;
        end
        check("small_fs_cnt",   32'(n_fs),     32'd2);
        check("small_vs_low",   32'(n_vs_low), 32'd64);
        check("small_hs_low",   32'(n_hs_low), 32'd54);
        check("small_tick_cnt", 32'(n_tick),   32'd288);
        check("small_vis_cnt",  32'(n_fg),     32'd64);

        // Small instance frame wrap (15,8) -> (0,0)
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (s_if.HCount == 10'd15 && s_if.VCount == 10'd8) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("small_wrap_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("small_wrap_h",  32'(s_if.HCount),      32'd0);
        check("small_wrap_v",  32'(s_if.VCount),      32'd0);
        check("small_wrap_fs", 32'(s_if.frame_start), 32'd1);
        @(negedge clk);
        check("small_fs_once", 32'(s_if.frame_start), 32'd0);
        check("small_h_step",  32'(s_if.HCount),      32'd1);

        // Line 1, renderer owns every pixel
        wait_start(10'd0, 10'd1, 4000);
        meas_line(9'h1C0, n_fg, n_zero, n_white, n_hs_low, n_tick);
        check("l1_card_cnt",  32'(n_fg),     32'd1280);
        check("l1_blank_cnt", 32'(n_zero),   32'd320);
        check("l1_hs_low",    32'(n_hs_low), 32'd192);
        check("l1_ticks",     32'(n_tick),   32'd800);
        check("l1_end_h",     32'(m_if.HCount),     32'd0);
        check("l1_end_v",     32'(m_if.VCount),     32'd2);
        check("l1_end_tick",  32'(m_if.pixel_tick), 32'd0);

        // Line 2, background only; renderer colour must be ignored
        m_if.card_on_in = 1'b0;
        m_if.rgb_in     = 9'h0AA;
        meas_line(9'h049, n_fg, n_zero, n_white, n_hs_low, n_tick);
        check("l2_bg_cnt",    32'(n_fg),     32'(1280 - c_BORDER_CLKS));
        check("l2_blank_cnt", 32'(n_zero),   32'd320);
        check("l2_white_cnt", 32'(n_white),  32'(c_BORDER_CLKS));
        check("l2_hs_low",    32'(n_hs_low), 32'd192);
        check("l2_end_v",     32'(m_if.VCount), 32'd3);

        // Line wrap (799,10) -> (0,11)
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (m_if.HCount == 10'd799 && m_if.VCount == 10'd10 && m_if.pixel_tick) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("line_wrap_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("lwrap_h",  32'(m_if.HCount),      32'd0);
        check("lwrap_v",  32'(m_if.VCount),      32'd11);
        check("lwrap_fs", 32'(m_if.frame_start), 32'd0);

        // Asynchronous reset mid-line at column 300
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_if.HCount == 10'd300) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) check("midrst_timeout", 32'd0, 32'd1);
        check("midrst_pre_rgb", 32'(m_if.rgb_out), 32'h049);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_hcount", 32'(m_if.HCount),      32'd0);
        check("midrst_vcount", 32'(m_if.VCount),      32'd0);
        check("midrst_tick",   32'(m_if.pixel_tick),  32'd0);
        check("midrst_fs",     32'(m_if.frame_start), 32'd0);
        check("midrst_hsync",  32'(m_if.hsync),       32'd1);
        check("midrst_vsync",  32'(m_if.vsync),       32'd1);
        check("midrst_rgb",    32'(m_if.rgb_out),     32'd0);
        @(negedge clk);
        check("midrst_hold_h", 32'(m_if.HCount),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrel_tick1",  32'(m_if.pixel_tick),  32'd1);
        check("midrel_h1",     32'(m_if.HCount),      32'd0);
        @(negedge clk);
        check("midrel_h2",     32'(m_if.HCount),      32'd1);
        check("midrel_v2",     32'(m_if.VCount),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
